// File: rtl/fib_sched.sv
// Round-robin scheduler that shares one Fib engine between NREQ requesters.
// The engine has no done flag, so each job runs for a fixed number of cycles:
// fib_start is held for START_CYCLES, then the result is sampled WAIT_CYCLES
// cycles after start falls and returned to the requester that was granted.
//
// Handshake: req[i] is a level request, sampled only while the FSM is IDLE.
// acc[i] pulses for one cycle at the edge the job is granted. rsp_valid[i]
// pulses for one cycle when rsp_data holds that job's result. A requester
// keeping req high past its rsp_valid is treated as asking for a new job.
// Request edges while busy are ignored; nothing is queued.
module fib_sched #(
  parameter int NREQ         = 4,
  parameter int N_W          = 3,
  parameter int R_W          = 5,
  parameter int START_CYCLES = 2,
  parameter int WAIT_CYCLES  = 100
) (
  input  logic                  clk,
  input  logic                  CLR,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*N_W-1:0]   req_n,
  output logic [NREQ-1:0]       acc,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [R_W-1:0]        rsp_data,
  output logic                  busy,
  output logic                  fib_start,
  output logic [N_W-1:0]        fib_n,
  input  logic [R_W-1:0]        fib_result,
  output logic [1:0]            dbg_state
);

  localparam int PTR_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_MAX = (START_CYCLES > WAIT_CYCLES) ? START_CYCLES : WAIT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [PTR_W-1:0] ptr, ptr_d;
  logic [NREQ-1:0]  acc_d, rsp_valid_d;
  logic [R_W-1:0]   rsp_data_d;
  logic             fib_start_d;
  logic [N_W-1:0]   fib_n_d;
  logic             found;
  logic [PTR_W-1:0] pick;

  assign busy      = (state != IDLE);
  assign dbg_state = state;

  // Round-robin search starting just above the last grant; ptr also names the
  // requester owning the job in flight, so it routes rsp_valid.
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && req[(int'(ptr) + k) % NREQ]) begin
        found = 1'b1;
        pick  = PTR_W'((int'(ptr) + k) % NREQ);
      end
    end
  end

  // Next-state and next-output logic; acc and rsp_valid default low so they
  // can only ever be single-cycle pulses.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    ptr_d       = ptr;
    acc_d       = '0;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data;
    fib_start_d = fib_start;
    fib_n_d     = fib_n;
    case (state)
      IDLE: begin
        if (found) begin
          acc_d[pick] = 1'b1;
          fib_n_d     = req_n[int'(pick)*N_W +: N_W];
          fib_start_d = 1'b1;
          ptr_d       = pick;
          cnt_d       = CNT_W'(START_CYCLES - 1);
          state_d     = START;
        end
      end
      START: begin
        if (cnt == '0) begin
          fib_start_d = 1'b0;
          cnt_d       = CNT_W'(WAIT_CYCLES - 1);
          state_d     = WAIT;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          rsp_data_d       = fib_result;
          rsp_valid_d[ptr] = 1'b1;
          state_d          = RESP;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any job in flight.
  always_ff @(posedge clk or negedge CLR) begin
    if (!CLR) begin
      state     <= IDLE;
      cnt       <= '0;
      ptr       <= PTR_W'(NREQ - 1);
      acc       <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      fib_start <= 1'b0;
      fib_n     <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      ptr       <= ptr_d;
      acc       <= acc_d;
      rsp_valid <= rsp_valid_d;
      rsp_data  <= rsp_data_d;
      fib_start <= fib_start_d;
      fib_n     <= fib_n_d;
    end
  end

endmodule
